integrator_scheduler: RTL and testbench

- Clocked, time-multiplexed integrator (glitch/debounce) controller for NUM_CH slow analog-comparator outputs.
- One scan sequencer services each channel in turn. Each channel keeps an integration counter and a reference level. A channel's output changes only after `thr` consecutive agreeing samples.
- Output changes are reported through a round-robin arbitrated valid/ready event port, for use by the digital control FSMs downstream of the analog cells.

---
 rtl/integrator_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_integrator_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/integrator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : integrator_scheduler
// Description : Time-multiplexed integrator (debounce) controller for NUM_CH
//               slow comparator outputs. A prescaled scan sequencer visits one
//               channel per slot. Each channel holds a reference level and an
//               integration counter. A channel's filtered output changes only
//               after `thr` consecutive agreeing samples. Output changes are
//               reported through a round-robin arbitrated valid/ready port.
// Ports       : clk, rst_n      - clock, asynchronous active-low reset
//               in[NUM_CH]      - raw asynchronous channel inputs
//               enable          - scan enable (event port runs regardless)
//               cfg_we, cfg_samples - threshold write strobe / value
//               out[NUM_CH]     - filtered levels
//               evt_valid/evt_ready/evt_ch/evt_level - event port
//               busy            - any pending event or event on the port
// Revision    : 1.0 - initial release
// ============================================================================
module integrator_scheduler #(
    parameter int NUM_CH          = 4,
    parameter int CH_W            = 2,
    parameter int CNT_W           = 4,
    parameter int PRESCALE        = 8,
    parameter int DEFAULT_SAMPLES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] in,
    input  logic              enable,
    input  logic              cfg_we,
    input  logic [CNT_W-1:0]  cfg_samples,
    output logic [NUM_CH-1:0] out,
    output logic              evt_valid,
    input  logic              evt_ready,
    output logic [CH_W-1:0]   evt_ch,
    output logic              evt_level,
    output logic              busy
);

    localparam int               PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]  PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PS_W-1:0]  PS_ONE  = PS_W'(1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'(DEFAULT_SAMPLES);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] sync1_q, sync1_d;
    logic [NUM_CH-1:0] sync2_q, sync2_d;
    logic [PS_W-1:0]   presc_q, presc_d;
    logic [CH_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]  thr_q,   thr_d;
    logic [NUM_CH-1:0] ref_q,   ref_d;
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] out_q,   out_d;
    logic [NUM_CH-1:0] pend_q,  pend_d;
    logic [CH_W-1:0]   rr_q,    rr_d;
    logic              evt_valid_q, evt_valid_d;
    logic [CH_W-1:0]   evt_ch_q,    evt_ch_d;
    logic              evt_level_q, evt_level_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              tick;
    logic [CNT_W-1:0]  thr_eff;
    logic              samp;
    logic [CNT_W-1:0]  svc_cnt;
    logic [NUM_CH-1:0] pend_set;
    logic [NUM_CH-1:0] pend_clr;
    logic              load;
    logic              found;
    logic [CH_W-1:0]   grant;

    // Synchronisers and prescaler
    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        tick    = enable && (presc_q == PS_MAX);
        presc_d = (!enable || tick) ? '0 : presc_q + PS_ONE;
        // A zero threshold is stored as written but behaves as one sample.
        thr_eff = (thr_q == '0) ? CNT_ONE : thr_q;
        // A write coinciding with a tick only affects later services,
        // because the service below reads thr_q, not thr_d.
        thr_d   = cfg_we ? cfg_samples : thr_q;
    end

    // Service of the channel under the scan pointer
    always_comb begin
        ref_d    = ref_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        ptr_d    = ptr_q;
        pend_set = '0;
        samp     = sync2_q[ptr_q];
        svc_cnt  = cnt_q[ptr_q];
        if (tick) begin
            if (samp != ref_q[ptr_q]) begin
                ref_d[ptr_q] = samp;
                svc_cnt      = CNT_ONE;
            end else if (cnt_q[ptr_q] < thr_eff) begin
                svc_cnt = cnt_q[ptr_q] + CNT_ONE;
            end
            cnt_d[ptr_q] = svc_cnt;
            // Qualification looks at the updated count and reference, so a
            // counter already above a lowered threshold qualifies right away.
            if ((svc_cnt >= thr_eff) && (ref_d[ptr_q] != out_q[ptr_q])) begin
                out_d[ptr_q]    = ref_d[ptr_q];
                pend_set[ptr_q] = 1'b1;
            end
            ptr_d = (ptr_q == CH_LAST) ? '0 : ptr_q + CH_ONE;
        end
    end

    // Round-robin event arbiter
    always_comb begin
        load  = !evt_valid_q || evt_ready;
        found = 1'b0;
        grant = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && pend_q[(int'(rr_q) + k) % NUM_CH]) begin
                found = 1'b1;
                grant = CH_W'((int'(rr_q) + k) % NUM_CH);
            end
        end

        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        evt_level_d = evt_level_q;
        rr_d        = rr_q;
        pend_clr    = '0;
        if (load) begin
            if (found) begin
                evt_valid_d     = 1'b1;
                evt_ch_d        = grant;
                evt_level_d     = out_q[grant];
                pend_clr[grant] = 1'b1;
                rr_d            = (grant == CH_LAST) ? '0 : grant + CH_ONE;
            end else begin
                evt_valid_d = 1'b0;
            end
        end
        // A new qualification beats a grant-clear of the same channel.
        pend_d = (pend_q & ~pend_clr) | pend_set;
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            presc_q     <= '0;
            ptr_q       <= '0;
            thr_q       <= THR_RST;
            ref_q       <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q       <= '0;
            pend_q      <= '0;
            rr_q        <= '0;
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            evt_level_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            presc_q     <= presc_d;
            ptr_q       <= ptr_d;
            thr_q       <= thr_d;
            ref_q       <= ref_d;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            out_q       <= out_d;
            pend_q      <= pend_d;
            rr_q        <= rr_d;
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            evt_level_q <= evt_level_d;
        end
    end

    assign out       = out_q;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;
    assign evt_level = evt_level_q;
    assign busy      = (|pend_q) | evt_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_integrator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_integrator_scheduler
// Description : Directed and randomized bench for integrator_scheduler with an
//               in-bench behavioural model of the debounce and event rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_integrator_scheduler;

    localparam int NUM_CH   = 4;
    localparam int CH_W     = 2;
    localparam int CNT_W    = 4;
    localparam int PRESCALE = 2;
    localparam int DEF_SAMP = 3;

    logic              clk         = 1'b0;
    logic              rst_n       = 1'b0;
    logic [NUM_CH-1:0] in          = '0;
    logic              enable      = 1'b0;
    logic              cfg_we      = 1'b0;
    logic [CNT_W-1:0]  cfg_samples = '0;
    logic              evt_ready   = 1'b0;
    logic [NUM_CH-1:0] out;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_level;
    logic              busy;

    integrator_scheduler #(
        .NUM_CH          (NUM_CH),
        .CH_W            (CH_W),
        .CNT_W           (CNT_W),
        .PRESCALE        (PRESCALE),
        .DEFAULT_SAMPLES (DEF_SAMP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .enable      (enable),
        .cfg_we      (cfg_we),
        .cfg_samples (cfg_samples),
        .out         (out),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_ch      (evt_ch),
        .evt_level   (evt_level),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    int          m_s1 [NUM_CH];
    int          m_s2 [NUM_CH];
    int          m_ref[NUM_CH];
    int          m_cnt[NUM_CH];
    logic [3:0]  m_out;
    logic [3:0]  m_pend;
    int          m_thr, m_pc, m_ptr, m_rr, m_ev, m_ch, m_lvl;

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_s1[c] = 0; m_s2[c] = 0; m_ref[c] = 0; m_cnt[c] = 0;
        end
        m_out = '0; m_pend = '0;
        m_thr = DEF_SAMP; m_pc = 0; m_ptr = 0; m_rr = 0;
        m_ev = 0; m_ch = 0; m_lvl = 0;
    endtask

    task automatic model_edge();
        logic [3:0] n_out;
        logic [3:0] n_pend;
        int g, c, te;
        bit tk;
        n_out  = m_out;
        n_pend = m_pend;
        tk     = enable && (m_pc == PRESCALE - 1);
        if (m_ev == 0 || evt_ready) begin
            g = -1;
            for (int k = 0; k < NUM_CH; k++)
                if (g < 0 && m_pend[(m_rr + k) % NUM_CH]) g = (m_rr + k) % NUM_CH;
            if (g >= 0) begin
                m_ev = 1; m_ch = g; m_lvl = int'(m_out[g]);
                n_pend[g] = 1'b0;
                m_rr = (g + 1) % NUM_CH;
            end else begin
                m_ev = 0;
            end
        end
        if (tk) begin
            c  = m_ptr;
            te = (m_thr == 0) ? 1 : m_thr;
            if (m_s2[c] != m_ref[c]) begin
                m_ref[c] = m_s2[c];
                m_cnt[c] = 1;
            end else if (m_cnt[c] < te) begin
                m_cnt[c] = m_cnt[c] + 1;
            end
            if (m_cnt[c] >= te && m_ref[c] != int'(m_out[c])) begin
                n_out[c]  = (m_ref[c] != 0);
                n_pend[c] = 1'b1;
            end
            m_ptr = (m_ptr + 1) % NUM_CH;
        end
        m_pc = (tk || !enable) ? 0 : m_pc + 1;
        for (int k = 0; k < NUM_CH; k++) begin
            m_s2[k] = m_s1[k];
            m_s1[k] = int'(in[k]);
        end
        if (cfg_we) m_thr = int'(cfg_samples);
        m_out  = n_out;
        m_pend = n_pend;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        chk("out", 32'(out), 32'(m_out));
        chk("evt_valid", 32'(evt_valid), 32'(m_ev));
        if (m_ev != 0) begin
            chk("evt_ch", 32'(evt_ch), 32'(m_ch));
            chk("evt_level", 32'(evt_level), 32'(m_lvl));
        end
        chk("busy", 32'(busy), 32'((m_pend != 0) || (m_ev != 0)));
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
        compare_all();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen, bsy, n;
        logic [3:0] frozen;
        model_reset();

        // Reset held while inputs toggle
        for (int i = 0; i < 6; i++) begin
            in = 4'(i * 5);
            step();
        end
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        in = '0;
        step();
        rst_n = 1'b1; enable = 1'b1; evt_ready = 1'b1;
        for (int i = 0; i < 4; i++) step();

        // Steady rise on channel 1
        in = 4'b0010;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (i == 25) chk("rise_by_26", 32'(out), 32'b0010);
            if (evt_valid === 1'b1) begin
                seen++;
                chk("rise_evt_ch", 32'(evt_ch), 32'd1);
                chk("rise_evt_level", 32'(evt_level), 32'd1);
            end
        end
        chk("rise_evt_pulses", 32'(seen), 32'd1);

        // Short glitch on channel 2 must be rejected
        in = 4'b0110;
        seen = 0; bsy = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (evt_valid === 1'b1) seen++;
            if (busy === 1'b1) bsy++;
        end
        in = 4'b0010;
        for (int i = 0; i < 30; i++) begin
            step();
            if (evt_valid === 1'b1) seen++;
            if (busy === 1'b1) bsy++;
        end
        chk("glitch_out", 32'(out), 32'b0010);
        chk("glitch_events", 32'(seen), 32'd0);
        chk("glitch_busy", 32'(bsy), 32'd0);

        // Simultaneous rise of channels 0 and 3 with the consumer stalled.
        // Align so channel 0 is the first of the two serviced after sync.
        evt_ready = 1'b0;
        n = 0;
        while (!(m_ptr == 3 && m_pc == 0) && n < 20) begin step(); n++; end
        chk("align_timeout", 32'(m_ptr == 3 && m_pc == 0), 32'd1);
        in = 4'b1011;
        n = 0;
        while (evt_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("sim_evt_seen", 32'(evt_valid), 32'd1);
        chk("sim_first_ch", 32'(evt_ch), 32'd0);
        chk("sim_first_lvl", 32'(evt_level), 32'd1);
        for (int i = 0; i < 9; i++) begin
            step();
            chk("sim_hold_valid", 32'(evt_valid), 32'd1);
            chk("sim_hold_ch", 32'(evt_ch), 32'd0);
        end
        evt_ready = 1'b1;
        step();
        chk("sim_second_ch", 32'(evt_ch), 32'd3);
        chk("sim_second_valid", 32'(evt_valid), 32'd1);
        step();
        chk("sim_drained", 32'(evt_valid), 32'd0);

        // Threshold 0 behaves as a single-sample filter
        cfg_samples = 4'd0; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        in = 4'b1111;
        n = 0;
        while (out[2] !== 1'b1 && n < 12) begin step(); n++; end
        chk("cfg0_out2", 32'(out[2]), 32'd1);
        chk("cfg0_latency", 32'(n <= 10), 32'd1);
        for (int i = 0; i < 4; i++) step();

        // Threshold 5 requires five agreeing services
        cfg_samples = 4'd5; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        in = 4'b1011;
        for (int i = 0; i < 20; i++) step();
        chk("cfg5_not_yet", 32'(out[2]), 32'd1);
        n = 0;
        while (out[2] !== 1'b0 && n < 40) begin step(); n++; end
        chk("cfg5_out2", 32'(out[2]), 32'd0);
        for (int i = 0; i < 4; i++) step();

        // Scan disabled: state frozen, pending events still drain
        evt_ready = 1'b0;
        cfg_samples = 4'd1; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        in = 4'b0100;
        n = 0;
        while (m_pend == 0 && n < 30) begin step(); n++; end
        enable = 1'b0;
        frozen = m_out;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) in[1] = ~in[1];
            if (i == 10) evt_ready = 1'b1;
            step();
        end
        chk("en0_frozen", 32'(out), 32'(frozen));
        chk("en0_drained", 32'(busy), 32'd0);
        enable = 1'b1;

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) in[$urandom_range(NUM_CH - 1)] ^= 1'b1;
            evt_ready = ($urandom_range(3) != 0);
            enable    = ($urandom_range(31) != 0);
            cfg_we    = ($urandom_range(63) == 0);
            cfg_samples = 4'($urandom_range(4));
            step();
        end
        cfg_we = 1'b0; enable = 1'b1;

        // Asynchronous reset in the middle of a cycle with events pending
        evt_ready = 1'b0;
        cfg_samples = 4'd1; cfg_we = 1'b1;
        step();
        cfg_we = 1'b0;
        in = ~out;
        n = 0;
        while ($countones(m_pend) < 2 && n < 60) begin step(); n++; end
        chk("arst_pre_busy", 32'(busy), 32'd1);
        chk("arst_pre_pend", 32'($countones(m_pend) >= 2), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out", 32'(out), 32'h0);
        chk("arst_valid", 32'(evt_valid), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        model_reset();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
